// File: rtl/regfile_wr_arbiter.sv
// Write-port arbiter for the register file: two 2-entry writeback FIFOs drained
// round-robin into a registered WE3/A3/WD1 stage.
//
// last_grant_q | meaning
// 0            | source 0 won the most recent grant; source 1 wins next contention
// 1            | source 1 won the most recent grant (reset); source 0 wins next contention
module regfile_wr_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s0_valid,
    output logic              s0_ready,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s1_valid,
    output logic              s1_ready,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [DATA_W-1:0] s1_data,
    output logic              WE3,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD1,
    output logic              idle
);

    localparam int EW = ADDR_W + DATA_W;

    logic [1:0]        cnt_q [2];
    logic [1:0]        cnt_d [2];
    logic [EW-1:0]     ent_q [2][2];
    logic [EW-1:0]     ent_d [2][2];
    logic [EW-1:0]     in_ent [2];
    logic [1:0]        push;
    logic [1:0]        pop;
    logic              gnt_vld;
    logic              gnt_src;
    logic [EW-1:0]     head;
    logic              last_grant_q, last_grant_d;
    logic              we3_q, we3_d;
    logic [ADDR_W-1:0] a3_q, a3_d;
    logic [DATA_W-1:0] wd1_q, wd1_d;

    assign s0_ready = (cnt_q[0] != 2'd2);
    assign s1_ready = (cnt_q[1] != 2'd2);
    assign WE3      = we3_q;
    assign A3       = a3_q;
    assign WD1      = wd1_q;
    assign idle     = (cnt_q[0] == 2'd0) & (cnt_q[1] == 2'd0) & ~we3_q;

    always_comb begin
        in_ent[0] = {s0_addr, s0_data};
        in_ent[1] = {s1_addr, s1_data};
        push[0]   = s0_valid & s0_ready;
        push[1]   = s1_valid & s1_ready;

        gnt_vld = (cnt_q[0] != 2'd0) | (cnt_q[1] != 2'd0);
        if ((cnt_q[0] != 2'd0) && (cnt_q[1] != 2'd0)) begin
            gnt_src = ~last_grant_q;
        end else begin
            gnt_src = (cnt_q[1] != 2'd0);
        end
        pop = 2'b00;
        if (gnt_vld) begin
            pop[gnt_src] = 1'b1;
        end
        head = ent_q[gnt_src][0];
    end

    // Slot 0 is always the head; a pop shifts slot 1 down, a push lands in the first free slot.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            cnt_d[i]    = cnt_q[i] + {1'b0, push[i]} - {1'b0, pop[i]};
            ent_d[i][0] = ent_q[i][0];
            ent_d[i][1] = ent_q[i][1];
            if (pop[i]) begin
                ent_d[i][0] = ent_q[i][1];
            end
            if (push[i]) begin
                if ((cnt_q[i] == 2'd0) || ((cnt_q[i] == 2'd1) && pop[i])) begin
                    ent_d[i][0] = in_ent[i];
                end else begin
                    ent_d[i][1] = in_ent[i];
                end
            end
        end
    end

    always_comb begin
        we3_d        = 1'b0;
        a3_d         = a3_q;
        wd1_d        = wd1_q;
        last_grant_d = last_grant_q;
        if (gnt_vld) begin
            last_grant_d = gnt_src;
            a3_d         = head[EW-1:DATA_W];
            wd1_d        = head[DATA_W-1:0];
            we3_d        = (head[EW-1:DATA_W] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q[0]     <= 2'd0;
            cnt_q[1]     <= 2'd0;
            last_grant_q <= 1'b1;
            we3_q        <= 1'b0;
            a3_q         <= '0;
            wd1_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            we3_q        <= we3_d;
            a3_q         <= a3_d;
            wd1_q        <= wd1_d;
        end
    end

    // Entry storage needs no reset: the counts decide what is valid.
    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_addr, s1_addr;
    logic [31:0] s0_data, s1_data;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD1;
    logic        idle;

    regfile_wr_arbiter #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_data(s1_data),
        .WE3(WE3), .A3(A3), .WD1(WD1), .idle(idle)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [4:0] a; logic [31:0] d; } ent_t;
    typedef struct { int cyc; logic [4:0] a; logic [31:0] d; } wr_t;

    ent_t        q0[$], q1[$];
    logic        m_last;
    logic        m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    wr_t         wlog[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // One clock edge: advance the model from the pre-edge inputs, then compare.
    task automatic tick();
        bit   acc0, acc1, any0, any1, win1;
        ent_t h, e;
        wr_t  w;
        @(posedge clk);
        if (!rst_n) begin
            q0.delete(); q1.delete();
            m_last = 1'b1; m_we = 1'b0; m_a3 = '0; m_wd = '0;
        end else begin
            acc0 = s0_valid && (q0.size() < 2);
            acc1 = s1_valid && (q1.size() < 2);
            any0 = q0.size() > 0;
            any1 = q1.size() > 0;
            m_we = 1'b0;
            if (any0 || any1) begin
                win1 = (any0 && any1) ? !m_last : any1;
                h = win1 ? q1.pop_front() : q0.pop_front();
                m_last = win1;
                m_a3 = h.a;
                m_wd = h.d;
                m_we = (h.a != 5'd0);
            end
            if (acc0) begin e.a = s0_addr; e.d = s0_data; q0.push_back(e); end
            if (acc1) begin e.a = s1_addr; e.d = s1_data; q1.push_back(e); end
        end
        cyc++;
        #1;
        chk("s0_ready", s0_ready, q0.size() != 2);
        chk("s1_ready", s1_ready, q1.size() != 2);
        chk("WE3", WE3, m_we);
        chk("A3", A3, m_a3);
        chk("WD1", WD1, m_wd);
        chk("idle", idle, (q0.size() == 0) && (q1.size() == 0) && !m_we);
        if (WE3 === 1'b1) begin
            w.cyc = cyc; w.a = A3; w.d = WD1;
            wlog.push_back(w);
        end
    endtask

    task automatic drain();
        s0_valid = 1'b0; s1_valid = 1'b0;
        for (int i = 0; i < 12 && !(q0.size() == 0 && q1.size() == 0 && !m_we); i++) tick();
        chk("drain_idle", idle, 1'b1);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int   p, acc, na0, na1, idx, s1w;
        bit   a0, a1, saw_block;
        logic [4:0]  sa [3];
        logic [31:0] sd [3];

        rst_n = 1'b1;
        s0_valid = 0; s1_valid = 0;
        s0_addr = 0; s1_addr = 0; s0_data = 0; s1_data = 0;
        m_last = 1'b1; m_we = 1'b0; m_a3 = '0; m_wd = '0;

        // Reset with both valids asserted.
        s0_valid = 1; s1_valid = 1; s0_addr = 5'd4; s1_addr = 5'd9;
        s0_data = 32'h1234; s1_data = 32'h5678;
        do_reset(2);
        s0_valid = 0; s1_valid = 0;
        chk("rst_we3", WE3, 1'b0);
        chk("rst_a3", A3, 5'd0);
        chk("rst_wd1", WD1, 32'd0);
        chk("rst_s0_ready", s0_ready, 1'b1);
        chk("rst_s1_ready", s1_ready, 1'b1);
        chk("rst_idle", idle, 1'b1);

        // Single-source stream.
        sa = '{5'd5, 5'd6, 5'd7};
        sd = '{32'h11, 32'h22, 32'h33};
        wlog.delete();
        p = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            s0_valid = 1; s0_addr = sa[i]; s0_data = sd[i];
            tick();
        end
        drain();
        chk("single_count", wlog.size(), 3);
        chk("single_lat0", wlog[0].cyc, p + 1);
        chk("single_lat1", wlog[1].cyc, p + 2);
        chk("single_lat2", wlog[2].cyc, p + 3);
        chk("single_w0", {wlog[0].a, wlog[0].d}, {5'd5, 32'h11});
        chk("single_w1", {wlog[1].a, wlog[1].d}, {5'd6, 32'h22});
        chk("single_w2", {wlog[2].a, wlog[2].d}, {5'd7, 32'h33});

        // Contention from a fresh reset: s0 first, then strict alternation.
        do_reset(1);
        wlog.delete();
        acc = 0; na0 = 1; na1 = 16;
        for (int i = 0; i < 12; i++) begin
            s0_valid = 1; s1_valid = 1;
            s0_addr = 5'(na0); s1_addr = 5'(na1);
            s0_data = $urandom; s1_data = $urandom;
            a0 = s0_ready; a1 = s1_ready;
            tick();
            if (a0) na0++;
            if (a1) na1++;
            acc += int'(a0) + int'(a1);
        end
        drain();
        chk("cont_no_loss", wlog.size(), acc);
        chk("cont_w0", wlog[0].a, 5'd1);
        chk("cont_w1", wlog[1].a, 5'd16);
        chk("cont_w2", wlog[2].a, 5'd2);
        chk("cont_w3", wlog[3].a, 5'd17);
        chk("cont_w4", wlog[4].a, 5'd3);
        chk("cont_w5", wlog[5].a, 5'd18);

        // Same-address collision, then an x0 write.
        do_reset(1);
        wlog.delete();
        s0_valid = 1; s0_addr = 5'd3; s0_data = 32'hAAAA;
        s1_valid = 1; s1_addr = 5'd3; s1_data = 32'hBBBB;
        tick();
        s0_valid = 0;
        s1_addr = 5'd0; s1_data = 32'hDEAD;
        tick();
        drain();
        chk("coll_count", wlog.size(), 2);
        chk("coll_first", {wlog[0].a, wlog[0].d}, {5'd3, 32'hAAAA});
        chk("coll_final", {wlog[1].a, wlog[1].d}, {5'd3, 32'hBBBB});
        chk("x0_a3", A3, 5'd0);
        chk("x0_wd1", WD1, 32'hDEAD);

        // Backpressure on s1 while s0 saturates; last grant was s1 after reset.
        do_reset(1);
        wlog.delete();
        idx = 0; na0 = 1; saw_block = 0;
        sa = '{5'd20, 5'd21, 5'd22};
        sd = '{32'hC0, 32'hC1, 32'hC2};
        for (int i = 0; i < 10; i++) begin
            s0_valid = 1; s0_addr = 5'(na0); s0_data = $urandom;
            s1_valid = (idx < 3);
            if (idx < 3) begin s1_addr = sa[idx]; s1_data = sd[idx]; end
            a0 = s0_ready; a1 = s1_valid && s1_ready;
            if (s1_valid && !s1_ready) saw_block = 1;
            tick();
            if (a0) na0 = (na0 % 15) + 1;
            if (a1) idx++;
        end
        drain();
        chk("bp_blocked", saw_block, 1'b1);
        chk("bp_all_pushed", idx, 3);
        s1w = 0;
        foreach (wlog[k]) begin
            if (wlog[k].a >= 5'd20) begin
                chk("bp_order", {wlog[k].a, wlog[k].d}, {sa[s1w], sd[s1w]});
                s1w++;
            end
        end
        chk("bp_s1_writes", s1w, 3);

        // Reset in the middle of saturated traffic.
        na0 = 1; na1 = 16;
        for (int i = 0; i < 6; i++) begin
            s0_valid = 1; s1_valid = 1;
            s0_addr = 5'(na0); s1_addr = 5'(na1);
            s0_data = $urandom; s1_data = $urandom;
            tick();
            na0++; na1++;
        end
        chk("mid_pre_we3", WE3, 1'b1);
        chk("mid_pre_busy", idle, 1'b0);
        do_reset(1);
        s0_valid = 0; s1_valid = 0;
        chk("mid_we3", WE3, 1'b0);
        chk("mid_s0_ready", s0_ready, 1'b1);
        chk("mid_s1_ready", s1_ready, 1'b1);
        wlog.delete();
        for (int i = 0; i < 5; i++) tick();
        chk("mid_no_stale", wlog.size(), 0);
        s0_valid = 1; s0_addr = 5'd9;  s0_data = 32'h99;
        s1_valid = 1; s1_addr = 5'd25; s1_data = 32'h25;
        tick();
        drain();
        chk("mid_first_s0", wlog[0].a, 5'd9);
        chk("mid_then_s1", wlog[1].a, 5'd25);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 199) != 0);
            s0_valid = ($urandom_range(0, 99) < 60);
            s1_valid = ($urandom_range(0, 99) < 60);
            s0_addr  = 5'($urandom_range(0, 31));
            s1_addr  = 5'($urandom_range(0, 31));
            s0_data  = $urandom;
            s1_data  = $urandom;
            tick();
        end
        rst_n = 1'b1;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
